// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// ---------------------------------------------------------------------------
// Central stall/flush sequencer for the 5-stage MIPS pipeline. It decides,
// every cycle, whether the pipeline registers hold, load a bubble or advance.
// It also handles redirecting the PC to a taken branch and freezing the
// pipeline while the data memory completes a slow access.
//
// Three sources compete for control of a cycle, highest priority first:
//   1. data-memory wait (multi-cycle load/store sitting in MEM)
//   2. taken branch resolved in MEM (mem_branch & mem_zero)
//   3. register data hazard between ID and younger stages
//
// Build option:
//   HAZ_FORWARD_EN  when defined, EX-stage forwarding selects are produced
//                   and only load-use hazards stall. When undefined,
//                   forwarding is off (fwd_a/fwd_b stay 00) and every RAW
//                   dependence on EX or MEM stalls until it drains.
//
// Parameters:
//   MEM_TIMEOUT  max cycles spent in MWAIT before the access is abandoned
//                (1..255)
//   CNT_W        width of the saturating stall-cycle counter
//
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   id_rs, id_rt, id_use_rs/rt    ID-stage source registers and use flags
//   ex_rs, ex_rt                  EX-stage source registers (forwarding)
//   ex_regwrite, ex_memread,
//   ex_wa                         EX-stage write enable, load flag, dest
//   mem_regwrite, mem_wa          MEM-stage write enable and dest
//   mem_branch, mem_zero          MEM-stage branch flag and ALU zero flag
//   mem_req, mem_ready            MEM-stage memory access and completion
//   wb_regwrite, wb_wa            WB-stage write enable and dest
//   pc_stall .. exmem_stall       hold the corresponding register
//   ifid_flush .. exmem_flush     load a bubble into the register
//   memwb_bubble                  load a bubble into MEM/WB
//   pc_sel_branch                 PC takes the branch target from EX/MEM
//   fwd_a, fwd_b                  EX operand select (00 RF, 10 MEM, 01 WB)
//   mem_err                       sticky memory-timeout flag
//   stall_cnt                     saturating count of pc_stall cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wa,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_wa,
  input  logic             mem_branch,
  input  logic             mem_zero,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_wa,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             pc_sel_branch,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // FSM encoding: RUN is normal flow, MWAIT holds the pipeline while the
  // data memory finishes a multi-cycle access.
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_MWAIT = 1'b1;

  localparam logic [7:0]       TIMEOUT_V = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [7:0] wcnt;
  logic [7:0] wcnt_nxt;
  logic       set_err;
  logic       mem_hold;
  logic       branch_taken;
  logic       data_hazard;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;
  logic       unused_inputs;

`ifdef HAZ_FORWARD_EN
  // With forwarding, only a load in EX whose result is needed by the
  // instruction in ID has to wait a cycle: its data does not exist until the
  // load leaves MEM. Everything else is bypassed into EX.
  always_comb begin
    data_hazard = ex_memread && (ex_wa != 5'd0) &&
                  ((id_use_rs && (ex_wa == id_rs)) ||
                   (id_use_rt && (ex_wa == id_rt)));
  end

  // Forwarding selects: the newer result (EX/MEM) wins over the older one
  // (MEM/WB). Register $0 is hard-wired to zero and is never forwarded.
  always_comb begin
    fwd_a_raw = 2'b00;
    if (mem_regwrite && (mem_wa != 5'd0) && (mem_wa == ex_rs))
      fwd_a_raw = 2'b10;
    else if (wb_regwrite && (wb_wa != 5'd0) && (wb_wa == ex_rs))
      fwd_a_raw = 2'b01;

    fwd_b_raw = 2'b00;
    if (mem_regwrite && (mem_wa != 5'd0) && (mem_wa == ex_rt))
      fwd_b_raw = 2'b10;
    else if (wb_regwrite && (wb_wa != 5'd0) && (wb_wa == ex_rt))
      fwd_b_raw = 2'b01;
  end

  assign unused_inputs = ex_regwrite;
`else
  // Without forwarding, any pending write in EX or MEM to a register the ID
  // instruction reads forces a stall. WB is not checked because the register
  // file writes in the first half of the cycle and ID reads in the second.
  // The stall repeats on its own until the producer drains past MEM, which
  // takes at most two cycles.
  always_comb begin
    data_hazard =
      (ex_regwrite && (ex_wa != 5'd0) &&
       ((id_use_rs && (ex_wa == id_rs)) || (id_use_rt && (ex_wa == id_rt)))) ||
      (mem_regwrite && (mem_wa != 5'd0) &&
       ((id_use_rs && (mem_wa == id_rs)) || (id_use_rt && (mem_wa == id_rt))));
  end

  // No bypass network in this build: EX always reads the register file.
  always_comb begin
    fwd_a_raw = 2'b00;
    fwd_b_raw = 2'b00;
  end

  assign unused_inputs = ^{ex_rs, ex_rt, ex_memread, wb_regwrite, wb_wa};
`endif

  // Memory-wait sequencing. In RUN a request that is not ready this cycle
  // freezes the pipeline and enters MWAIT with the wait counter at 1. In
  // MWAIT the freeze is kept until the memory answers or the counter reaches
  // MEM_TIMEOUT; either way the release cycle itself is not frozen. On a
  // timeout the access is simply dropped and mem_err records it.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    set_err   = 1'b0;
    mem_hold  = 1'b0;
    case (state)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          mem_hold  = 1'b1;
          state_nxt = ST_MWAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      ST_MWAIT: begin
        if (mem_ready) begin
          state_nxt = ST_RUN;
          wcnt_nxt  = 8'd0;
        end else if (wcnt >= TIMEOUT_V) begin
          set_err   = 1'b1;
          state_nxt = ST_RUN;
          wcnt_nxt  = 8'd0;
        end else begin
          mem_hold  = 1'b1;
          wcnt_nxt  = wcnt + 8'd1;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        wcnt_nxt  = 8'd0;
      end
    endcase
  end

  // A branch only counts when no memory operation occupies MEM. A branch
  // flagged together with mem_req is an illegal combination and is ignored.
  assign branch_taken = (state == ST_RUN) && !mem_req && mem_branch && mem_zero;

  // Output decode in priority order. Every cycle spent in MWAIT, including
  // the release cycle, belongs to the memory sequencer, so branch and hazard
  // handling only act from RUN. Everything is forced low while reset is high.
  always_comb begin
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    idex_stall    = 1'b0;
    exmem_stall   = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_bubble  = 1'b0;
    pc_sel_branch = 1'b0;
    fwd_a         = 2'b00;
    fwd_b         = 2'b00;
    if (!reset) begin
      fwd_a = fwd_a_raw;
      fwd_b = fwd_b_raw;
      if (mem_hold) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
      end else if (branch_taken) begin
        // The three younger instructions were fetched down the wrong path.
        pc_sel_branch = 1'b1;
        ifid_flush    = 1'b1;
        idex_flush    = 1'b1;
        exmem_flush   = 1'b1;
      end else if ((state == ST_RUN) && data_hazard) begin
        // Hold PC and IF/ID so ID retries, and send a bubble down into EX.
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  // FSM state, wait counter and sticky error flag. Reset abandons any
  // access in progress and returns straight to RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_RUN;
      wcnt    <= 8'd0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (set_err)
        mem_err <= 1'b1;
    end
  end

  // Performance counter: counts cycles in which the PC was held, and sticks
  // at all-ones rather than wrapping so a saturated value is recognisable.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (pc_stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// ---------------------------------------------------------------------------
// Directed bench for pipe_hazard_ctrl. Built with MEM_TIMEOUT=4 and CNT_W=4
// so the timeout and the counter saturation are reachable in a few cycles.
// Expected control words are written out by hand per cycle; the stall
// counter expectation is kept as a small saturating tally of expected
// pc_stall cycles. Expectations that differ between builds follow
// HAZ_FORWARD_EN.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wa, mem_wa, wb_wa;
  logic       id_use_rs, id_use_rt, ex_regwrite, ex_memread;
  logic       mem_regwrite, mem_branch, mem_zero, mem_req, mem_ready;
  logic       wb_regwrite;
  logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic       ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_sel_branch;
  logic [1:0] fwd_a, fwd_b;
  logic       mem_err;
  logic [3:0] stall_cnt;

  // Packed control word:
  // {pc_stall, ifid_stall, idex_stall, exmem_stall,
  //  ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_sel_branch}
  logic [8:0] ctl;
  assign ctl = {pc_stall, ifid_stall, idex_stall, exmem_stall,
                ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_sel_branch};

  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] HAZ  = 9'b110001000;
  localparam logic [8:0] MEMW = 9'b111100010;
  localparam logic [8:0] BR   = 9'b000011101;

`ifdef HAZ_FORWARD_EN
  localparam logic [8:0] LU2  = NONE;
  localparam logic [1:0] FA1  = 2'b10;
  localparam logic [1:0] FB1  = 2'b01;
  localparam logic [1:0] FB2  = 2'b10;
`else
  localparam logic [8:0] LU2  = HAZ;
  localparam logic [1:0] FA1  = 2'b00;
  localparam logic [1:0] FB1  = 2'b00;
  localparam logic [1:0] FB2  = 2'b00;
`endif

  int         check_count;
  int         pass_count;
  logic [3:0] exp_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_wa(ex_wa),
    .mem_regwrite(mem_regwrite), .mem_wa(mem_wa),
    .mem_branch(mem_branch), .mem_zero(mem_zero),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .wb_regwrite(wb_regwrite), .wb_wa(wb_wa),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_bubble(memwb_bubble),
    .pc_sel_branch(pc_sel_branch), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_output(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, actual, expected, $time);
    end
  endtask

  // Drive every input to its idle value.
  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_wa = 5'd0;
    ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_regwrite = 1'b0; mem_wa = 5'd0;
    mem_branch = 1'b0; mem_zero = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    wb_regwrite = 1'b0; wb_wa = 5'd0;
  endtask

  // Let the inputs set up for this cycle settle, check the control word,
  // update the expected stall tally, then move to 1 ns after the next edge.
  task automatic apply_stimulus(input string tag, input logic [8:0] exp_ctl);
    #2;
    check_output(tag, {7'd0, ctl}, {7'd0, exp_ctl});
    if (exp_ctl[8] && (exp_cnt != 4'hF))
      exp_cnt = exp_cnt + 4'd1;
    @(posedge clk);
    #1;
  endtask

  // Convenience for the cycle-by-cycle stall counter check.
  task automatic check_cnt(input string tag);
    check_output(tag, {12'd0, stall_cnt}, {12'd0, exp_cnt});
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    exp_cnt     = 4'd0;

    // Reset with hostile inputs: every output must stay low.
    clear_inputs();
    reset = 1'b1;
    mem_req = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1;
    ex_rs = 5'd8; mem_regwrite = 1'b1; mem_wa = 5'd8;
    #2;
    check_output("reset_fwd_a", {14'd0, fwd_a}, 16'd0);
    apply_stimulus("reset_ctl_0", NONE);
    apply_stimulus("reset_ctl_1", NONE);
    reset = 1'b0;
    clear_inputs();
    check_output("reset_mem_err", {15'd0, mem_err}, 16'd0);
    check_cnt("reset_stall_cnt");

    // Load-use: lw $8 in EX, add reads $8 in ID.
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wa = 5'd8;
    id_rs = 5'd8; id_use_rs = 1'b1; id_rt = 5'd9; id_use_rt = 1'b1;
    apply_stimulus("lu_cycle1", HAZ);
    // Load now in MEM, bubble in EX, add still in ID.
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_wa = 5'd0;
    mem_regwrite = 1'b1; mem_wa = 5'd8;
    apply_stimulus("lu_cycle2", LU2);
    // Load in WB: write-before-read, so no hazard from WB.
    mem_regwrite = 1'b0; mem_wa = 5'd0;
    wb_regwrite = 1'b1; wb_wa = 5'd8;
    apply_stimulus("lu_wb_nohaz", NONE);
    check_cnt("lu_stall_cnt");

    // Writes to $0 and unused sources never cause a stall.
    clear_inputs();
    ex_regwrite = 1'b1; ex_memread = 1'b1; ex_wa = 5'd0;
    id_rs = 5'd0; id_use_rs = 1'b1;
    apply_stimulus("reg0_nohaz", NONE);
    ex_wa = 5'd8; id_rs = 5'd8; id_use_rs = 1'b0;
    apply_stimulus("unused_src", NONE);

    // rt path of the hazard compare.
    clear_inputs();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wa = 5'd12;
    id_rt = 5'd12; id_use_rt = 1'b1;
    apply_stimulus("rt_haz", HAZ);

    // Taken branch beats a data hazard in the same cycle.
    clear_inputs();
    mem_branch = 1'b1; mem_zero = 1'b1;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wa = 5'd5;
    id_rs = 5'd5; id_use_rs = 1'b1;
    apply_stimulus("branch_taken", BR);
    clear_inputs();
    mem_branch = 1'b1; mem_zero = 1'b0;
    apply_stimulus("branch_not_taken", NONE);
    // Branch flagged with a memory request is ignored.
    mem_branch = 1'b1; mem_zero = 1'b1; mem_req = 1'b1; mem_ready = 1'b1;
    apply_stimulus("branch_with_memreq", NONE);

    // Forwarding selects (all 00 when forwarding is compiled out).
    clear_inputs();
    ex_rs = 5'd8; ex_rt = 5'd9;
    mem_regwrite = 1'b1; mem_wa = 5'd8;
    wb_regwrite = 1'b1; wb_wa = 5'd9;
    #2;
    check_output("fwd_a_mem", {14'd0, fwd_a}, {14'd0, FA1});
    check_output("fwd_b_wb", {14'd0, fwd_b}, {14'd0, FB1});
    mem_wa = 5'd9;
    #1;
    check_output("fwd_b_mem_priority", {14'd0, fwd_b}, {14'd0, FB2});
    check_output("fwd_a_nomatch", {14'd0, fwd_a}, 16'd0);
    mem_wa = 5'd0; wb_wa = 5'd0; ex_rs = 5'd0; ex_rt = 5'd0;
    #1;
    check_output("fwd_reg0", {12'd0, fwd_a, fwd_b}, 16'd0);
    apply_stimulus("fwd_ctl", NONE);

    // Memory wait: ready low 3 cycles, release on the ready cycle.
    clear_inputs();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      apply_stimulus("mwait_hold", MEMW);
    mem_ready = 1'b1;
    apply_stimulus("mwait_release", NONE);
    clear_inputs();
    apply_stimulus("mwait_back_to_run", NONE);
    check_output("mwait_no_err", {15'd0, mem_err}, 16'd0);
    check_cnt("mwait_stall_cnt");

    // Timeout: ready never rises, MEM_TIMEOUT=4.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      apply_stimulus("timeout_hold", MEMW);
    check_output("timeout_err_not_yet", {15'd0, mem_err}, 16'd0);
    apply_stimulus("timeout_release", NONE);
    clear_inputs();
    check_output("timeout_err_set", {15'd0, mem_err}, 16'd1);
    apply_stimulus("timeout_run", NONE);
    check_output("timeout_err_sticky", {15'd0, mem_err}, 16'd1);
    check_cnt("timeout_stall_cnt");

    // Keep timing out until the stall counter saturates at 15.
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++)
      apply_stimulus("sat_cycle", ((i % 5) == 4) ? NONE : MEMW);
    check_cnt("sat_stall_cnt");
    check_output("sat_cnt_all_ones", {12'd0, stall_cnt}, 16'h000F);

    // Reset in the middle of MWAIT abandons the access.
    apply_stimulus("pre_reset_hold", MEMW);
    apply_stimulus("pre_reset_mwait", MEMW);
    reset = 1'b1;
    apply_stimulus("reset_in_mwait", NONE);
    exp_cnt = 4'd0;
    reset = 1'b0;
    clear_inputs();
    apply_stimulus("after_reset_run", NONE);
    check_output("after_reset_err", {15'd0, mem_err}, 16'd0);
    check_cnt("after_reset_cnt");

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
